// File: rtl/pulse_barrier_pkg.sv
// Shared defaults for the pulse barrier: channel count, credit and round counter widths.
package pulse_barrier_pkg;

  localparam int unsigned DEF_NUM_PULSES = 2;
  localparam int unsigned DEF_CNT_W      = 2;
  localparam int unsigned DEF_ROUND_W    = 16;

endpackage

// File: rtl/pulse_credit_ctr.sv
// One channel's saturating credit counter with sticky overflow; updates one cycle after inc/dec.
// No backpressure: an increment arriving at max is dropped and flagged instead.
module pulse_credit_ctr
  import pulse_barrier_pkg::*;
#(
  parameter int unsigned P_CNT_W = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic nonzero_o,
  output logic overflow_o
);

  localparam logic [P_CNT_W-1:0] CNT_MAX = '1;

  logic [P_CNT_W-1:0] cnt;

  // Simultaneous inc and dec cancel, so a pulse landing at max while firing is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      overflow_o <= 1'b0;
    end else if (clear_i) begin
      cnt        <= '0;
      overflow_o <= 1'b0;
    end else if (inc_i && !dec_i) begin
      if (cnt == CNT_MAX) begin
        overflow_o <= 1'b1;
      end else begin
        cnt <= cnt + P_CNT_W'(1);
      end
    end else if (dec_i && !inc_i && (cnt != '0)) begin
      cnt <= cnt - P_CNT_W'(1);
    end
  end

  assign nonzero_o = |cnt;

endmodule

// File: rtl/pulse_barrier.sv
// Barrier over per-channel done pulses: pulse_o fires once every enabled channel holds a credit.
// Latency: last pulse in cycle N -> pulse_o in N+2. No backpressure; credits saturate and flag overflow.
module pulse_barrier
  import pulse_barrier_pkg::*;
#(
  parameter int unsigned P_NUM_PULSES = DEF_NUM_PULSES,
  parameter int unsigned P_CNT_W      = DEF_CNT_W,
  parameter int unsigned P_ROUND_W    = DEF_ROUND_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [P_NUM_PULSES-1:0] enable_mask_i,
  input  logic [P_NUM_PULSES-1:0] pulse_vector_i,
  input  logic                    clear_i,
  output logic                    pulse_o,
  output logic [P_NUM_PULSES-1:0] pending_o,
  output logic [P_NUM_PULSES-1:0] overflow_o,
  output logic [P_ROUND_W-1:0]    round_cnt_o
);

  logic [P_NUM_PULSES-1:0] inc;
  logic [P_NUM_PULSES-1:0] dec;
  logic [P_NUM_PULSES-1:0] nonzero;
  logic                    fire;

  // Masked channels count as satisfied, but an empty mask never fires.
  assign inc  = pulse_vector_i & enable_mask_i;
  assign fire = (|enable_mask_i) && (&(nonzero | ~enable_mask_i));
  assign dec  = enable_mask_i & {P_NUM_PULSES{fire}};

  for (genvar i = 0; i < P_NUM_PULSES; i++) begin : g_ch
    pulse_credit_ctr #(
      .P_CNT_W (P_CNT_W)
    ) u_ctr (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (clear_i),
      .inc_i      (inc[i]),
      .dec_i      (dec[i]),
      .nonzero_o  (nonzero[i]),
      .overflow_o (overflow_o[i])
    );
  end

  assign pending_o = nonzero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_o     <= 1'b0;
      round_cnt_o <= '0;
    end else if (clear_i) begin
      pulse_o     <= 1'b0;
      round_cnt_o <= '0;
    end else begin
      pulse_o <= fire;
      if (fire) begin
        round_cnt_o <= round_cnt_o + P_ROUND_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pulse_barrier.sv
// Randomized + directed bench for pulse_barrier with a credit-count reference model and scoreboard.
module tb_pulse_barrier;

  localparam int NP  = 3;
  localparam int CW  = 2;
  localparam int RW  = 4;
  localparam int MAXC = (1 << CW) - 1;
  localparam int QD  = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] enable_mask_i;
  logic [NP-1:0] pulse_vector_i;
  logic          clear_i;
  logic          pulse_o;
  logic [NP-1:0] pending_o;
  logic [NP-1:0] overflow_o;
  logic [RW-1:0] round_cnt_o;

  pulse_barrier #(
    .P_NUM_PULSES (NP),
    .P_CNT_W      (CW),
    .P_ROUND_W    (RW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable_mask_i  (enable_mask_i),
    .pulse_vector_i (pulse_vector_i),
    .clear_i        (clear_i),
    .pulse_o        (pulse_o),
    .pending_o      (pending_o),
    .overflow_o     (overflow_o),
    .round_cnt_o    (round_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          pulse;
    logic [NP-1:0] pend;
    logic [NP-1:0] ovf;
    logic [RW-1:0] rnd;
  } exp_t;

  // Expected-output FIFO: stimulus side writes entries and wr_idx, monitor owns rd_idx.
  exp_t exp_q [QD];
  int   wr_idx = 0;
  int   rd_idx = 0;
  bit   done   = 1'b0;

  // Reference model state: plain integer credit counts per channel.
  int        mcnt [NP];
  bit [NP-1:0] movf;
  int        mround;

  task automatic push(input exp_t e);
    exp_q[wr_idx % QD] = e;
    wr_idx++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) mcnt[i] = 0;
    movf   = '0;
    mround = 0;
  endtask

  // Applies one clock edge worth of barrier rules to the model and queues the expected outputs.
  task automatic model_edge();
    exp_t e;
    bit   fire;
    bit   pulse;
    int   n;
    pulse = 1'b0;
    if (clear_i) begin
      model_reset();
    end else begin
      fire = (enable_mask_i != '0);
      for (int i = 0; i < NP; i++)
        if (enable_mask_i[i] && mcnt[i] == 0) fire = 1'b0;
      for (int i = 0; i < NP; i++) begin
        n = mcnt[i];
        if (enable_mask_i[i] && pulse_vector_i[i]) n = n + 1;
        if (enable_mask_i[i] && fire) n = n - 1;
        if (n > MAXC) begin
          n = MAXC;
          movf[i] = 1'b1;
        end
        mcnt[i] = n;
      end
      pulse = fire;
      if (fire) mround = (mround + 1) % (1 << RW);
    end
    e.pulse = pulse;
    for (int i = 0; i < NP; i++) e.pend[i] = (mcnt[i] != 0);
    e.ovf = movf;
    e.rnd = RW'(mround);
    push(e);
  endtask

  task automatic cyc(input logic [NP-1:0] m, input logic [NP-1:0] pv, input logic c);
    enable_mask_i  = m;
    pulse_vector_i = pv;
    clear_i        = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(3'b111, 3'b000, 1'b0);
  endtask

  // Asserts rst mid-cycle; the not-yet-checked entry for this cycle becomes all-zero.
  task automatic do_reset();
    #1;
    rst            = 1'b1;
    enable_mask_i  = '0;
    pulse_vector_i = '0;
    clear_i        = 1'b0;
    model_reset();
    exp_q[(wr_idx - 1) % QD] = '0;
    @(negedge clk);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    enable_mask_i  = '0;
    pulse_vector_i = '0;
    clear_i        = 1'b0;
    model_reset();
    push('0);
    #12;
    rst = 1'b0;

    // Staggered arrival: fire two cycles after the last channel's pulse.
    cyc(3'b111, 3'b001, 1'b0); idle(2);
    cyc(3'b111, 3'b010, 1'b0); idle(1);
    cyc(3'b111, 3'b100, 1'b0); idle(4);

    // Buffered credits on ch0 give three back-to-back fires.
    for (int k = 0; k < 3; k++) cyc(3'b111, 3'b001, 1'b0);
    idle(7);
    for (int k = 0; k < 3; k++) cyc(3'b111, 3'b110, 1'b0);
    idle(5);

    // Saturation and sticky overflow, then clear.
    for (int k = 0; k < 5; k++) cyc(3'b111, 3'b001, 1'b0);
    idle(4);
    cyc(3'b111, 3'b000, 1'b1);
    idle(2);

    // Masked channel ignored.
    cyc(3'b011, 3'b011, 1'b0);
    cyc(3'b011, 3'b100, 1'b0);
    cyc(3'b011, 3'b000, 1'b0); idle(2);

    // Clear overrides an imminent fire.
    cyc(3'b111, 3'b111, 1'b0);
    cyc(3'b111, 3'b000, 1'b1);
    idle(3);

    // All-zero mask never fires even with credits held.
    cyc(3'b111, 3'b111, 1'b0);
    cyc(3'b000, 3'b111, 1'b0);
    cyc(3'b000, 3'b000, 1'b0);
    idle(3);

    // Async reset with credits pending, then a lone ch2 pulse must not fire.
    cyc(3'b111, 3'b011, 1'b0);
    cyc(3'b111, 3'b000, 1'b0);
    do_reset();
    cyc(3'b111, 3'b100, 1'b0); idle(4);

    for (int k = 0; k < 800; k++) begin
      logic [NP-1:0] m;
      logic [NP-1:0] pv;
      m  = ($urandom_range(0, 9) == 0) ? NP'($urandom_range(0, 7)) : 3'b111;
      pv = ($urandom_range(0, 2) == 0) ? 3'b000 : NP'($urandom_range(0, 7));
      cyc(m, pv, ($urandom_range(0, 39) == 0));
      if ($urandom_range(0, 119) == 0) do_reset();
    end
    idle(3);
    enable_mask_i  = '0;
    pulse_vector_i = '0;
    done = 1'b1;
  end

  int   total  = 0;
  int   bad    = 0;
  int   cycles = 0;
  exp_t cur;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    cycles++;
    if (rd_idx != wr_idx) begin
      cur = exp_q[rd_idx % QD];
      rd_idx++;
      chk("pulse_o",     int'(pulse_o),     int'(cur.pulse));
      chk("pending_o",   int'(pending_o),   int'(cur.pend));
      chk("overflow_o",  int'(overflow_o),  int'(cur.ovf));
      chk("round_cnt_o", int'(round_cnt_o), int'(cur.rnd));
    end
    if (done && rd_idx == wr_idx) begin
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end else if (cycles > 20000) begin
      total++;
      bad++;
      $display("FAIL watchdog: cycles=%0d expected completion, pending entries=%0d", cycles, wr_idx - rd_idx);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

endmodule

// File: doc/pulse_barrier.md
PULSE_BARRIER -- requirements
Module: pulse_barrier

Interface
REQ-001 Parameter P_NUM_PULSES, default 2: number of input pulse channels, >=1.
REQ-002 Parameter P_CNT_W, default 2: per-channel credit counter width, >=1; max credits = 2^P_CNT_W-1.
REQ-003 Parameter P_ROUND_W, default 16: completed-round counter width, >=1.
REQ-004 clk  input  1  single clock, all logic rising-edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 enable_mask_i  input  P_NUM_PULSES  1 = channel participates in barrier.
REQ-007 pulse_vector_i  input  P_NUM_PULSES  single-cycle done pulses, one per channel.
REQ-008 clear_i  input  1  synchronous clear of all state.
REQ-009 pulse_o  output  1  registered single-cycle barrier-complete pulse.
REQ-010 pending_o  output  P_NUM_PULSES  bit i = channel i credit count nonzero.
REQ-011 overflow_o  output  P_NUM_PULSES  sticky, bit i = channel i lost a pulse to saturation.
REQ-012 round_cnt_o  output  P_ROUND_W  number of pulse_o assertions since reset/clear, wraps.

Function
REQ-013 Each channel SHALL hold a credit counter cnt[i], incremented by 1 when pulse_vector_i[i] & enable_mask_i[i] is high at a rising edge.
REQ-014 Masked channels (enable_mask_i[i]=0) SHALL ignore pulses, hold their count, and never be decremented.
REQ-015 fire = (enable_mask_i != 0) & (every enabled channel has cnt[i] != 0), evaluated on registered counts.
REQ-016 On fire, every enabled counter SHALL decrement by 1 at the same edge; pulse_o SHALL be registered high for exactly the cycle following fire.
REQ-017 Latency: last required pulse high in cycle N, counters previously zero -> pulse_o high in cycle N+2.
REQ-018 Increment and decrement in the same cycle SHALL leave cnt[i] unchanged.
REQ-019 Counters SHALL saturate at 2^P_CNT_W-1; an increment at max without simultaneous decrement SHALL set overflow_o[i], held until clear/reset.
REQ-020 Buffered credits SHALL allow fire on consecutive cycles, giving back-to-back pulse_o cycles.
REQ-021 round_cnt_o SHALL increment by 1 at each fire, wrapping modulo 2^P_ROUND_W.
REQ-022 clear_i SHALL zero all counters, overflow_o, round_cnt_o and pulse_o at the next edge; clear_i overrides concurrent pulses and fire, so no pulse_o results.
REQ-023 All-zero enable_mask_i SHALL never fire.
REQ-024 pending_o SHALL be combinational from registered counts, with no input-to-output combinational path.

Reset
REQ-025 rst high SHALL asynchronously force cnt[*]=0, pulse_o=0, pending_o=0, overflow_o=0, round_cnt_o=0, including mid-operation with credits pending.
REQ-026 After rst deasserts, the first sampled edge SHALL behave as a fresh start; no pulse_o SHALL be generated from pre-reset pulses.

Structure
REQ-027 A shared package SHALL hold the default parameter constants (P_CNT_W, P_ROUND_W defaults).
REQ-028 One sub-module pulse_credit_ctr SHALL implement one saturating up/down counter with overflow flag, instantiated P_NUM_PULSES times by generate loop.
REQ-029 Top-level SHALL hold the fire reduction, pulse_o register and round counter.

Verification (P_NUM_PULSES=3, P_CNT_W=2, mask=3'b111 unless stated)
REQ-030 ch0 pulse at cycle 0, ch1 at cycle 3, ch2 at cycle 5 -> pulse_o high only in cycle 7; pending_o=0 from cycle 7; round_cnt_o=1.
REQ-031 ch0 pulses cycles 0-2, ch1 and ch2 pulse cycles 10-12 -> pulse_o high in cycles 12, 13, 14; all counts 0 after cycle 14; round_cnt_o=3.
REQ-032 ch0 pulses 5 consecutive cycles, no others -> cnt0 saturates at 3, overflow_o=3'b001 from the cycle after the 4th pulse, held until clear_i.
REQ-033 mask=3'b011, ch0 and ch1 pulse at cycle 0, ch2 pulses at cycle 1 -> pulse_o in cycle 2; ch2 pulse ignored, pending_o[2]=0.
REQ-034 ch0-ch2 all pulse at cycle 0, clear_i high in cycle 1 -> no pulse_o; counts, overflow_o and round_cnt_o are 0 from cycle 2.
REQ-035 Credits pending on ch0 and ch1, rst pulsed asynchronously mid-cycle -> all outputs 0 immediately; a subsequent ch2-only pulse produces no pulse_o.
